// File: rtl/uart_rx_if.sv
// Consumer-side bus of the UART receiver: received byte, strobes, ack and status.
// Parity ports exist only when UART_RX_PARITY_EN is defined.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] RxD_data;
    logic                 RxD_ready;
    logic                 RxD_ack;
    logic                 frame_err;
    logic                 overrun;
    logic                 Busy;
`ifdef UART_RX_PARITY_EN
    logic                 parity_odd;
    logic                 parity_err;
`endif

    // master = the receiver producing bytes, slave = the consumer reading them
    modport master (
        output RxD_data, RxD_ready, frame_err, overrun, Busy,
`ifdef UART_RX_PARITY_EN
        output parity_err,
        input  parity_odd,
`endif
        input  RxD_ack
    );

    modport slave (
        input  RxD_data, RxD_ready, frame_err, overrun, Busy,
`ifdef UART_RX_PARITY_EN
        input  parity_err,
        output parity_odd,
`endif
        output RxD_ack
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: synchronized, oversampled line; mid-bit sampling, LSB first;
// byte with ready pulse, framing and overrun flags. Parity via UART_RX_PARITY_EN.
//
// state       | meaning
// S_IDLE      | line idle, waiting for a tick with rxs low
// S_START     | counting to mid start bit, rejecting glitches
// S_DATA      | sampling DATA_BITS data bits at mid bit
// S_PARITY    | sampling the parity bit (parity build only)
// S_STOP      | sampling the stop bit
// S_WAIT_HIGH | framing error seen, waiting for the line to return high
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      RxD,
    input  logic      SampleTick,
    uart_rx_if.master bus
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY    = 3'd3,
`endif
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } state_t;

    state_t               state, state_nx;
    logic                 rx_meta, rxs;
    logic [TW-1:0]        tick_cnt, tick_cnt_nx;
    logic [BW-1:0]        bit_cnt, bit_cnt_nx;
    logic [DATA_BITS-1:0] shreg, shreg_nx;
    logic [DATA_BITS-1:0] data_q;
    logic                 ready_q, ferr_q, pending, ovr_q;
    logic                 stop_mid, deliver, ferr_now, busy;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit, par_bit_nx, par_odd_q, par_odd_nx;
    logic                 perr_now, perr_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta   <= 1'b1;
            rxs       <= 1'b1;
            state     <= S_IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
`ifdef UART_RX_PARITY_EN
            par_bit   <= 1'b0;
            par_odd_q <= 1'b0;
`endif
        end else begin
            rx_meta   <= RxD;
            rxs       <= rx_meta;
            state     <= state_nx;
            tick_cnt  <= tick_cnt_nx;
            bit_cnt   <= bit_cnt_nx;
            shreg     <= shreg_nx;
`ifdef UART_RX_PARITY_EN
            par_bit   <= par_bit_nx;
            par_odd_q <= par_odd_nx;
`endif
        end
    end

    always_comb begin
        state_nx    = state;
        tick_cnt_nx = tick_cnt;
        bit_cnt_nx  = bit_cnt;
        shreg_nx    = shreg;
`ifdef UART_RX_PARITY_EN
        par_bit_nx  = par_bit;
        par_odd_nx  = par_odd_q;
`endif
        if (SampleTick) begin
            case (state)
                S_IDLE: begin
                    if (!rxs) begin
                        state_nx    = S_START;
                        tick_cnt_nx = '0;
                    end
                end
                S_START: begin
                    if (tick_cnt == HALF_M1) begin
                        if (rxs) begin
                            state_nx = S_IDLE;
                        end else begin
                            state_nx    = S_DATA;
                            tick_cnt_nx = '0;
                            bit_cnt_nx  = '0;
`ifdef UART_RX_PARITY_EN
                            par_odd_nx  = bus.parity_odd;
`endif
                        end
                    end else begin
                        tick_cnt_nx = tick_cnt + TW'(1);
                    end
                end
                S_DATA: begin
                    if (tick_cnt == FULL_M1) begin
                        shreg_nx    = {rxs, shreg[DATA_BITS-1:1]};
                        tick_cnt_nx = '0;
                        bit_cnt_nx  = bit_cnt + BW'(1);
                        if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_nx = S_PARITY;
`else
                            state_nx = S_STOP;
`endif
                        end
                    end else begin
                        tick_cnt_nx = tick_cnt + TW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (tick_cnt == FULL_M1) begin
                        par_bit_nx  = rxs;
                        tick_cnt_nx = '0;
                        state_nx    = S_STOP;
                    end else begin
                        tick_cnt_nx = tick_cnt + TW'(1);
                    end
                end
`endif
                S_STOP: begin
                    // IDLE is re-entered at mid stop bit so back-to-back frames are accepted
                    if (tick_cnt == FULL_M1) begin
                        tick_cnt_nx = '0;
                        state_nx    = rxs ? S_IDLE : S_WAIT_HIGH;
                    end else begin
                        tick_cnt_nx = tick_cnt + TW'(1);
                    end
                end
                S_WAIT_HIGH: begin
                    if (rxs) state_nx = S_IDLE;
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_comb begin
        stop_mid = (state == S_STOP) && SampleTick && (tick_cnt == FULL_M1);
        deliver  = stop_mid && rxs;
        ferr_now = stop_mid && !rxs;
        busy     = (state != S_IDLE);
`ifdef UART_RX_PARITY_EN
        perr_now = deliver && ((^{shreg, par_bit}) != par_odd_q);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            ready_q <= 1'b0;
            ferr_q  <= 1'b0;
            pending <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            ready_q <= deliver;
            ferr_q  <= ferr_now;
`ifdef UART_RX_PARITY_EN
            perr_q  <= perr_now;
`endif
            // an ack coinciding with a new byte retires the old one, so no overrun
            if (deliver) begin
                data_q  <= shreg;
                pending <= 1'b1;
                ovr_q   <= bus.RxD_ack ? 1'b0 : (ovr_q | pending);
            end else if (bus.RxD_ack) begin
                pending <= 1'b0;
                ovr_q   <= 1'b0;
            end
        end
    end

    assign bus.RxD_data  = data_q;
    assign bus.RxD_ready = ready_q;
    assign bus.frame_err = ferr_q;
    assign bus.overrun   = ovr_q;
    assign bus.Busy      = busy;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = perr_q;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx: a serializer drives frames, a frame-level model
// predicts every ready/frame_err pulse, data, overrun and parity result.
module tb_uart_rx;
    localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
    localparam int NPAR = 1;
`else
    localparam int NPAR = 0;
`endif

    typedef struct {
        logic [7:0] d;
        bit         stop_ok;
        bit         par;
        bit         podd;
    } frame_t;

    logic clk, rst, RxD, SampleTick;
    uart_rx_if #(.DATA_BITS(8)) bus ();

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(OS)) dut (
        .clk(clk), .rst(rst), .RxD(RxD), .SampleTick(SampleTick), .bus(bus)
    );

    int total = 0, bad = 0;
    int cyc = 0, tp = 4, tk = 0;
    int ready_cnt = 0, ferr_cnt = 0, perr_cnt = 0;
    int last_ready_cyc = 0, t0_cyc = 0;
    bit auto_ack = 1, manual_ack = 0;
    frame_t exp_q[$];
    logic [7:0] m_data;
    bit m_pend, m_ov;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc = cyc + 1;

    initial begin
        SampleTick = 0;
        forever begin
            @(negedge clk);
            tk = (tk + 1 >= tp) ? 0 : tk + 1;
            SampleTick = (tk == 0);
        end
    end

    initial begin
        bus.RxD_ack = 0;
        forever begin
            @(negedge clk);
            bus.RxD_ack = (auto_ack && bus.RxD_ready === 1'b1) || manual_ack;
        end
    end

    task automatic wait_tick();
        do @(posedge clk); while (SampleTick !== 1'b1);
    endtask

    // hold the line at b for n ticks; returns just after a tick edge
    task automatic drive(input bit b, input int n);
        RxD = b;
        repeat (n) wait_tick();
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par, input int extra_low);
        frame_t f;
        f.d = d; f.stop_ok = stop_ok; f.par = par;
`ifdef UART_RX_PARITY_EN
        f.podd = bus.parity_odd;
`else
        f.podd = 0;
`endif
        exp_q.push_back(f);
        t0_cyc = cyc;
        drive(0, OS);
        for (int i = 0; i < 8; i++) drive(d[i], OS);
`ifdef UART_RX_PARITY_EN
        drive(par, OS);
`endif
        if (stop_ok) drive(1, OS);
        else begin
            drive(0, OS + extra_low);
            drive(1, 4);
        end
    endtask

    // frame-level model: every pulse must match the next queued frame
    initial begin
        frame_t f;
        m_data = 0; m_pend = 0; m_ov = 0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                m_data = 0; m_pend = 0; m_ov = 0;
            end else begin
                if (bus.RxD_ready || bus.frame_err) begin
                    if (exp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_pulse: ready=%0b frame_err=%0b, none expected (cycle %0d)",
                                 bus.RxD_ready, bus.frame_err, cyc);
                    end else begin
                        f = exp_q.pop_front();
                        chk("ready_vs_stop", bus.RxD_ready, f.stop_ok);
                        chk("frame_err_vs_stop", bus.frame_err, !f.stop_ok);
                        if (f.stop_ok) begin
                            m_ov   = bus.RxD_ack ? 1'b0 : (m_ov | m_pend);
                            m_pend = 1;
                            m_data = f.d;
                            ready_cnt++;
                            last_ready_cyc = cyc;
                        end else ferr_cnt++;
`ifdef UART_RX_PARITY_EN
                        chk("parity_err", bus.parity_err, f.stop_ok && (((^f.d) ^ f.par) != f.podd));
                        if (bus.parity_err) perr_cnt++;
`endif
                    end
                end else begin
                    if (bus.RxD_ack) begin
                        m_pend = 0; m_ov = 0;
                    end
`ifdef UART_RX_PARITY_EN
                    chk("parity_err_idle", bus.parity_err, 0);
`endif
                end
                chk("RxD_data", bus.RxD_data, m_data);
                chk("overrun", bus.overrun, m_ov);
            end
        end
    end

    initial begin
        logic [7:0] d;
        rst = 1; RxD = 1;
`ifdef UART_RX_PARITY_EN
        bus.parity_odd = 0;
`endif
        repeat (5) @(negedge clk);
        chk("rst_data", bus.RxD_data, 0);
        chk("rst_ready", bus.RxD_ready, 0);
        chk("rst_ferr", bus.frame_err, 0);
        chk("rst_overrun", bus.overrun, 0);
        chk("rst_busy", bus.Busy, 0);
        rst = 0;
        drive(1, 4);

        // single byte, ticks every 4 clk: ready 153 ticks after the start edge
        send_frame(8'h55, 1, 0, 0);
        drive(1, 4);
        chk("latency_clk", last_ready_cyc - t0_cyc, 4 * (1 + OS / 2 + (8 + NPAR) * OS + OS));
        chk("data_55", bus.RxD_data, 8'h55);
        chk("ready_cnt_1", ready_cnt, 1);
        chk("ferr_cnt_0", ferr_cnt, 0);
        chk("busy_after", bus.Busy, 0);

        // back-to-back frames with ack
        send_frame(8'hA3, 1, 1, 0);
        send_frame(8'h0F, 1, 0, 0);
        drive(1, 4);
        chk("data_0f", bus.RxD_data, 8'h0F);
        chk("ovr_b2b", bus.overrun, 0);
        chk("ready_cnt_3", ready_cnt, 3);

        // no ack: second byte overruns
        auto_ack = 0;
        send_frame(8'h11, 1, 0, 0);
        send_frame(8'h22, 1, 0, 0);
        drive(1, 4);
        chk("data_22", bus.RxD_data, 8'h22);
        chk("ovr_set", bus.overrun, 1);
        manual_ack = 1;
        @(posedge clk); @(posedge clk); #1;
        chk("ovr_cleared", bus.overrun, 0);
        manual_ack = 0;
        auto_ack = 1;
        @(negedge clk);
        drive(1, 2);

        // start glitch of 5 ticks
        drive(0, 5);
        drive(1, 5);
        chk("glitch_busy", bus.Busy, 0);
        drive(1, 6);
        chk("glitch_no_ready", ready_cnt, 5);

        // bad stop, line held low, then a valid frame
        send_frame(8'h3C, 0, 0, 40);
        chk("ferr_cnt_1", ferr_cnt, 1);
        chk("data_kept", bus.RxD_data, 8'h22);
        send_frame(8'h7E, 1, 0, 0);
        drive(1, 4);
        chk("data_7e", bus.RxD_data, 8'h7E);

`ifdef UART_RX_PARITY_EN
        bus.parity_odd = 0;
        send_frame(8'h07, 1, 0, 0);
        send_frame(8'h07, 1, 1, 0);
        drive(1, 4);
        chk("perr_cnt_1", perr_cnt, 1);
        chk("data_07", bus.RxD_data, 8'h07);
`endif

        // randomized frames, tick rates, gaps, glitches, ack behaviour
        for (int n = 0; n < 30; n++) begin
            tp = $urandom_range(1, 4);
            auto_ack = ($urandom_range(0, 3) != 0);
`ifdef UART_RX_PARITY_EN
            bus.parity_odd = 1'($urandom_range(0, 1));
`endif
            if ($urandom_range(0, 5) == 0) begin
                drive(1, 2);
                drive(0, $urandom_range(1, 5));
                drive(1, 12);
            end
            d = 8'($urandom);
            send_frame(d, $urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 40));
            drive(1, $urandom_range(0, 6));
        end
        tp = 4;
        auto_ack = 1;
        drive(1, 20);
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(posedge clk);
        chk("queue_drained", exp_q.size(), 0);

        // reset in the middle of a frame
        send_frame(8'hC5, 1, 0, 0);
        drive(1, 4);
        drive(0, OS);
        drive(1, OS);
        drive(0, 5);
        rst = 1;
        #1;
        chk("midrst_data", bus.RxD_data, 0);
        chk("midrst_ready", bus.RxD_ready, 0);
        chk("midrst_ferr", bus.frame_err, 0);
        chk("midrst_busy", bus.Busy, 0);
        RxD = 1;
        repeat (3) @(negedge clk);
        rst = 0;
        d = 8'(ready_cnt);
        drive(1, 200);
        chk("midrst_no_pulse", ready_cnt, d);
        chk("midrst_ovr", bus.overrun, 0);
        chk("midrst_busy_after", bus.Busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000000;
        $display("FAIL timeout: run did not finish, bound expired");
        $fatal(1, "timeout");
    end
endmodule
